execute_stage: RTL and testbench

- EX stage of the 5-stage pipeline; consumes the 4-bit ALUControl produced by the ALU decoder in ID.
- Contains the ID/EX pipeline register, operand forwarding muxes, the ALU, and the EX/MEM pipeline register.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.
- Drives a combinational zero flag for branch resolution in EX.

---
 rtl/execute_stage.sv | 166 ++++++++++++++++
 tb/tb_execute_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage integer pipeline.
//
// Holds the ID/EX pipeline register, the operand forwarding muxes, the ALU
// and the EX/MEM pipeline register. The hazard unit can stall both
// registers with hold_e or turn the instruction entering EX into a bubble
// with flush_e.
//
// Optional feature: define EX_FORWARD_EN to enable operand forwarding from
// the EX/MEM ALU result and the writeback value. When it is not defined the
// ForwardA_e/ForwardB_e/result_w ports are still present but ignored, and
// operands always come from the ID/EX register.
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   hold_e, flush_e       stall both registers / bubble into ID/EX
//   valid_d .. rd_d       decoded instruction fields from ID
//   ForwardA_e/B_e        00/11: ID/EX value, 10: EX/MEM result, 01: result_w
//   result_w              writeback value for forwarding
//   zero_e                combinational ALU result == 0, gated by EX valid
//   valid_m .. RegWrite_m EX/MEM register outputs

module execute_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hold_e,
    input  logic            flush_e,
    input  logic            valid_d,
    input  logic [3:0]      ALUControl_d,
    input  logic            ALUSrc_d,
    input  logic            RegWrite_d,
    input  logic [XLEN-1:0] rd1_d,
    input  logic [XLEN-1:0] rd2_d,
    input  logic [XLEN-1:0] imm_d,
    input  logic [4:0]      rd_d,
    input  logic [1:0]      ForwardA_e,
    input  logic [1:0]      ForwardB_e,
    input  logic [XLEN-1:0] result_w,
    output logic            zero_e,
    output logic            valid_m,
    output logic [XLEN-1:0] ALUResult_m,
    output logic [XLEN-1:0] WriteData_m,
    output logic [4:0]      rd_m,
    output logic            RegWrite_m
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;

    // ID/EX register
    logic            valid_e;
    logic [3:0]      alu_control_e;
    logic            alu_src_e;
    logic            reg_write_e;
    logic [XLEN-1:0] rd1_e;
    logic [XLEN-1:0] rd2_e;
    logic [XLEN-1:0] imm_e;
    logic [4:0]      rd_e;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_e       <= 1'b0;
            alu_control_e <= '0;
            alu_src_e     <= 1'b0;
            reg_write_e   <= 1'b0;
            rd1_e         <= '0;
            rd2_e         <= '0;
            imm_e         <= '0;
            rd_e          <= '0;
        end else if (!hold_e) begin
            // A flush only kills the control bits; the data fields of a
            // bubble are never observed, so they load unconditionally.
            valid_e       <= valid_d & ~flush_e;
            reg_write_e   <= RegWrite_d & ~flush_e;
            alu_control_e <= ALUControl_d;
            alu_src_e     <= ALUSrc_d;
            rd1_e         <= rd1_d;
            rd2_e         <= rd2_d;
            imm_e         <= imm_d;
            rd_e          <= rd_d;
        end
    end

    // Operand selection
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] rs2_fwd;
    logic [XLEN-1:0] src_b;

`ifdef EX_FORWARD_EN
    always_comb begin
        case (ForwardA_e)
            2'b10:   src_a = ALUResult_m;
            2'b01:   src_a = result_w;
            default: src_a = rd1_e;
        endcase
        case (ForwardB_e)
            2'b10:   rs2_fwd = ALUResult_m;
            2'b01:   rs2_fwd = result_w;
            default: rs2_fwd = rd2_e;
        endcase
    end
`else
    assign src_a   = rd1_e;
    assign rs2_fwd = rd2_e;

    // Forwarding ports are kept for a stable port list but have no effect.
    logic unused_fwd;
    assign unused_fwd = ^{ForwardA_e, ForwardB_e, result_w};
`endif

    assign src_b = alu_src_e ? imm_e : rs2_fwd;

    // ALU
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_result;

    assign shamt = src_b[SHW-1:0];

    always_comb begin
        alu_result = '0;
        case (alu_control_e)
            ALU_ADD:  alu_result = src_a + src_b;
            ALU_SUB:  alu_result = src_a - src_b;
            ALU_AND:  alu_result = src_a & src_b;
            ALU_OR:   alu_result = src_a | src_b;
            ALU_SLL:  alu_result = src_a << shamt;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            ALU_XOR:  alu_result = src_a ^ src_b;
            ALU_SRA:  alu_result = $signed(src_a) >>> shamt;
            ALU_SRL:  alu_result = src_a >> shamt;
            default:  alu_result = '0;
        endcase
    end

    assign zero_e = valid_e & (alu_result == '0);

    // EX/MEM register
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_m     <= 1'b0;
            ALUResult_m <= '0;
            WriteData_m <= '0;
            rd_m        <= '0;
            RegWrite_m  <= 1'b0;
        end else if (!hold_e) begin
            valid_m     <= valid_e;
            ALUResult_m <= alu_result;
            WriteData_m <= rs2_fwd;
            rd_m        <= rd_e;
            RegWrite_m  <= valid_e & reg_write_e;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: randomized + directed scoreboard bench for execute_stage.
// A transaction-level model predicts the EX/MEM contents after every clock
// edge and the zero flag during every EX cycle; a monitor process pops the
// predictions and compares them with the DUT outputs after each edge.

module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset, hold_e, flush_e, valid_d, ALUSrc_d, RegWrite_d;
    logic [3:0]  ALUControl_d;
    logic [31:0] rd1_d, rd2_d, imm_d, result_w;
    logic [4:0]  rd_d;
    logic [1:0]  ForwardA_e, ForwardB_e;
    logic        zero_e, valid_m, RegWrite_m;
    logic [31:0] ALUResult_m, WriteData_m;
    logic [4:0]  rd_m;

    always #5 clk = ~clk;

    execute_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .hold_e(hold_e), .flush_e(flush_e),
        .valid_d(valid_d), .ALUControl_d(ALUControl_d), .ALUSrc_d(ALUSrc_d),
        .RegWrite_d(RegWrite_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
        .rd_d(rd_d), .ForwardA_e(ForwardA_e), .ForwardB_e(ForwardB_e),
        .result_w(result_w), .zero_e(zero_e), .valid_m(valid_m),
        .ALUResult_m(ALUResult_m), .WriteData_m(WriteData_m), .rd_m(rd_m),
        .RegWrite_m(RegWrite_m)
    );

    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic        src;
        logic        regw;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rd;
    } ex_t;

    typedef struct packed {
        logic        chk_data;   // data fields are defined (after reset)
        logic        valid;
        logic [31:0] res;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        regw;
    } mem_t;

    ex_t  ex;
    mem_t m;
    mem_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   known  = 1'b0;

    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int unsigned sh;
        logic [31:0] ones;
        logic [31:0] r;
        sh   = b % 32;
        ones = 32'hFFFF_FFFF;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a + ~b + 32'd1;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a << sh;
            4'd5: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd6: r = (a < b) ? 32'd1 : 32'd0;
            4'd7: r = a ^ b;
            4'd8: r = (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
            4'd9: r = a >> sh;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] fwd(logic [1:0] sel, logic [31:0] regval);
`ifdef EX_FORWARD_EN
        if (sel == 2'b10) return m.res;
        if (sel == 2'b01) return result_w;
        return regval;
`else
        return regval;
`endif
    endfunction

    // Called just after a falling edge with inputs already set; checks the
    // zero flag, predicts the outcome of the next rising edge, then waits
    // for the following falling edge.
    task automatic step();
        logic [31:0] a, b2, b, r;
        logic        zexp;
        #1;
        a  = fwd(ForwardA_e, ex.rd1);
        b2 = fwd(ForwardB_e, ex.rd2);
        b  = ex.src ? ex.imm : b2;
        r  = ref_alu(ex.op, a, b);
        if (known) begin
            zexp = ex.valid && (r == 32'd0);
            checks++;
            if (zero_e !== zexp) begin
                errors++;
                $display("FAIL zero_e t=%0t got %b want %b", $time, zero_e, zexp);
            end
        end
        if (reset) begin
            ex    = '0;
            m     = '0;
            m.chk_data = 1'b1;
            known = 1'b1;
        end else if (!hold_e) begin
            m.chk_data = 1'b0;
            m.valid    = ex.valid;
            m.res      = r;
            m.wd       = b2;
            m.rd       = ex.rd;
            m.regw     = ex.valid & ex.regw;
            ex.valid   = valid_d & ~flush_e;
            ex.regw    = RegWrite_d & ~flush_e;
            ex.op      = ALUControl_d;
            ex.src     = ALUSrc_d;
            ex.rd1     = rd1_d;
            ex.rd2     = rd2_d;
            ex.imm     = imm_d;
            ex.rd      = rd_d;
        end
        exp_q.push_back(m);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        mem_t e;
        bit   ok;
        forever begin
            @(posedge clk);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty t=%0t no prediction for this edge", $time);
            end else begin
                e  = exp_q.pop_front();
                ok = (valid_m === e.valid) && (RegWrite_m === e.regw);
                if (e.valid || e.chk_data)
                    ok = ok && (ALUResult_m === e.res) && (WriteData_m === e.wd) && (rd_m === e.rd);
                if (!ok) begin
                    errors++;
                    $display("FAIL ex_mem t=%0t got v=%b rw=%b res=%h wd=%h rd=%0d want v=%b rw=%b res=%h wd=%h rd=%0d",
                             $time, valid_m, RegWrite_m, ALUResult_m, WriteData_m, rd_m,
                             e.valid, e.regw, e.res, e.wd, e.rd);
                end
            end
        end
    end

    task automatic idle();
        reset = 1'b0; hold_e = 1'b0; flush_e = 1'b0; valid_d = 1'b0;
        RegWrite_d = 1'b0; ForwardA_e = 2'b00; ForwardB_e = 2'b00;
    endtask

    task automatic set_instr(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                             logic [31:0] imm, logic src, logic [4:0] rd,
                             logic [1:0] fa, logic [1:0] fb);
        valid_d = 1'b1; RegWrite_d = 1'b1; ALUControl_d = op;
        rd1_d = a; rd2_d = b; imm_d = imm; ALUSrc_d = src; rd_d = rd;
        ForwardA_e = fa; ForwardB_e = fb;
    endtask

    task automatic issue(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] imm, logic src, logic [4:0] rd,
                         logic [1:0] fa, logic [1:0] fb);
        idle();
        set_instr(op, a, b, imm, src, rd, fa, fb);
        step();
    endtask

    task automatic bubble();
        idle();
        step();
    endtask

    task automatic rand_inputs();
        valid_d      = $urandom_range(0, 3) != 0;
        RegWrite_d   = 1'($urandom);
        ALUControl_d = ($urandom_range(0, 4) != 0) ? 4'($urandom_range(0, 9)) : 4'($urandom);
        ALUSrc_d     = 1'($urandom);
        rd1_d        = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom;
        rd2_d        = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom;
        imm_d        = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom;
        rd_d         = 5'($urandom);
        ForwardA_e   = 2'($urandom);
        ForwardB_e   = 2'($urandom);
        result_w     = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom;
    endtask

    initial begin
        ex = '0;
        m  = '0;
        idle();
        result_w = 32'd0;

        // Reset with random inputs, then first add shows up two edges later
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            hold_e  = 1'($urandom);
            flush_e = 1'($urandom);
            reset   = 1'b1;
            step();
        end
        issue(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 5'd3, 2'b00, 2'b00);
        bubble();
        bubble();

        // Full ALU sweep plus an unused code
        for (int op = 0; op < 10; op++)
            issue(4'(op), 32'hFFFF_FFF0, 32'h0000_0004, 32'd0, 1'b0, 5'(op + 1), 2'b00, 2'b00);
        issue(4'hF, 32'hFFFF_FFF0, 32'h0000_0004, 32'd0, 1'b0, 5'd20, 2'b00, 2'b00);
        bubble();
        bubble();

        // Immediate operand giving a zero result
        issue(4'd0, 32'd5, 32'd9, 32'hFFFF_FFFB, 1'b1, 5'd7, 2'b00, 2'b00);
        bubble();
        bubble();

        // Back-to-back dependent adds
        issue(4'd0, 32'd2, 32'd3, 32'd0, 1'b0, 5'd1, 2'b00, 2'b00);
        issue(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd2, 2'b10, 2'b10);
        bubble();
        bubble();
        issue(4'd0, 32'd2, 32'd3, 32'd0, 1'b0, 5'd1, 2'b00, 2'b00);
        result_w = 32'd7;
        issue(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd2, 2'b10, 2'b01);
        result_w = 32'd0;
        bubble();
        bubble();

        // Flush of a valid sub in ID while another sub is in EX
        issue(4'd1, 32'd10, 32'd3, 32'd0, 1'b0, 5'd4, 2'b00, 2'b00);
        idle();
        set_instr(4'd1, 32'd20, 32'd5, 32'd0, 1'b0, 5'd5, 2'b00, 2'b00);
        flush_e = 1'b1;
        step();
        bubble();
        bubble();

        // Three-cycle hold with a flush in the middle
        issue(4'd1, 32'd9, 32'd4, 32'd0, 1'b0, 5'd6, 2'b00, 2'b00);
        issue(4'd7, 32'h0F0F_0000, 32'h00FF_00FF, 32'd0, 1'b0, 5'd8, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) begin
            idle();
            set_instr(4'd3, 32'h1, 32'h2, 32'd0, 1'b0, 5'd9, 2'b00, 2'b00);
            hold_e  = 1'b1;
            flush_e = (i == 1);
            step();
        end
        idle();
        set_instr(4'd3, 32'h1, 32'h2, 32'd0, 1'b0, 5'd9, 2'b00, 2'b00);
        step();
        bubble();
        bubble();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            reset   = ($urandom_range(0, 49) == 0);
            hold_e  = ($urandom_range(0, 5) == 0);
            flush_e = ($urandom_range(0, 5) == 0);
            step();
        end
        bubble();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
